// File: rtl/lector_contador.sv
// rtl/lector_contador.sv - counter read initiator: sweeps idx, captures counts, reports done
//
// Purpose: on start, request each counter index 0..NUM_IDX-1 in turn (one req per
// index, only while IDLE is high), capture the count returned with valid_contador,
// and present every count together with a one-cycle done pulse. An index whose
// response does not arrive within TIMEOUT cycles is recorded as 0 and flagged.
//
// Ports:
//   clk             in   clock, all logic on posedge
//   reset           in   synchronous, active-low reset
//   start           in   one-cycle pulse that begins a sweep (ignored while busy)
//   IDLE            in   counter side idle; a request is only issued while high
//   valid_contador  in   counter response strobe
//   contador_out    in   count for the index currently requested
//   req             out  one-cycle request strobe
//   idx             out  index being requested
//   conteos         out  captured counts, index k at [k*CNT_W +: CNT_W]
//   err_mask        out  bit k set: index k timed out and its count was forced to 0
//   busy            out  sweep in progress
//   done            out  one-cycle pulse: sweep finished, conteos/err_mask valid
module lector_contador #(
    parameter int NUM_IDX = 5,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       IDLE,
    input  logic                       valid_contador,
    input  logic [CNT_W-1:0]           contador_out,
    output logic                       req,
    output logic [2:0]                 idx,
    output logic [NUM_IDX*CNT_W-1:0]   conteos,
    output logic [NUM_IDX-1:0]         err_mask,
    output logic                       busy,
    output logic                       done
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_IDX - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        PEDIR     = 2'd1,
        RESPUESTA = 2'd2,
        SIGUIENTE = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [2:0]                 r_idx;
    logic [TO_W-1:0]            r_cnt;
    logic [NUM_IDX*CNT_W-1:0]   r_conteos;
    logic [NUM_IDX-1:0]         r_err;
    logic                       w_timeout;

    // r_cnt counts RESPUESTA cycles already spent; when it reads TIMEOUT-1 this is
    // the last cycle a response is accepted, so it advances to TIMEOUT on exit.
    assign w_timeout = (r_cnt == TO_LAST);

    assign idx      = r_idx;
    assign conteos  = r_conteos;
    assign err_mask = r_err;

    always_comb begin
        w_next = r_state;
        req    = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            ESPERA: begin
                busy = 1'b0;
                if (start) begin
                    w_next = PEDIR;
                end
            end
            PEDIR: begin
                if (IDLE) begin
                    req    = 1'b1;
                    w_next = RESPUESTA;
                end
            end
            RESPUESTA: begin
                // A response on the final allowed cycle still counts as a response.
                if (valid_contador || w_timeout) begin
                    w_next = SIGUIENTE;
                end
            end
            SIGUIENTE: begin
                if (r_idx == LAST_IDX) begin
                    done   = 1'b1;
                    w_next = ESPERA;
                end else begin
                    w_next = PEDIR;
                end
            end
            default: w_next = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ESPERA;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_conteos <= '0;
            r_err     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ESPERA: begin
                    // Counts from the previous sweep stay visible until overwritten.
                    if (start) begin
                        r_err <= '0;
                        r_idx <= '0;
                    end
                end
                RESPUESTA: begin
                    r_cnt <= r_cnt + 1'b1;
                    for (int k = 0; k < NUM_IDX; k++) begin
                        if (r_idx == 3'(k)) begin
                            if (valid_contador) begin
                                r_conteos[k*CNT_W +: CNT_W] <= contador_out;
                            end else if (w_timeout) begin
                                r_conteos[k*CNT_W +: CNT_W] <= '0;
                                r_err[k]                    <= 1'b1;
                            end
                        end
                    end
                end
                SIGUIENTE: begin
                    r_cnt <= '0;
                    r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
